// File: rtl/rv_pkg.sv
// Shared fetch-side types and constants for the RV front end.
package rv_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned ILEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes consumed by the controller
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC owner, single-outstanding imem handshake, redirect handling.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned    XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    fetch_state_e    r_state;
    fetch_state_e    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;

    logic            w_handshake;
    logic            w_capture;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_handshake   = (r_state == HOLD) && instr_ready;
    assign w_capture     = (r_state == WAIT) && imem_rvalid && !redirect;
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; redirect takes priority over every other event
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = REQ;
            REQ: begin
                if (imem_gnt) w_next_state = redirect ? FLUSH : WAIT;
            end
            WAIT: begin
                if (redirect)         w_next_state = imem_rvalid ? REQ : FLUSH;
                else if (imem_rvalid) w_next_state = HOLD;
            end
            HOLD: begin
                if (redirect || instr_ready) w_next_state = REQ;
            end
            FLUSH: begin
                if (imem_rvalid) w_next_state = REQ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // PC: redirect target wins, otherwise advance on decode handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_pc <= RESET_PC;
        else if (redirect)    r_pc <= w_redirect_pc;
        else if (w_handshake) r_pc <= r_pc + XLEN'(4);
    end

    // Output registers: strobes follow next state, instruction captured on accepted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
        end else begin
            r_imem_req    <= (w_next_state == REQ);
            r_instr_valid <= (w_next_state == HOLD);
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[6:0];
    assign funct3      = r_instr[14:12];
    assign funct7      = r_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a response scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h5A3C_0F33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_req();
        int i = 0;
        while (imem_req !== 1'b1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
    endtask

    // One full fetch from exp_pc; decode stalls 'hold' cycles, optional redirect on handshake
    task automatic fetch(input int hold, input logic redir, input logic [31:0] tgt);
        logic [31:0] w;
        logic [63:0] e;
        logic [31:0] ew;
        wait_req();
        check("req_addr", imem_addr, exp_pc);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check("wait_no_req", 32'(imem_req), 32'd0);
        check("wait_no_valid", 32'(instr_valid), 32'd0);
        w = mem_word(exp_pc);
        sb.push_back({w, exp_pc});
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("hold_valid", 32'(instr_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        ew = e[63:32];
        check("instr", instr, ew);
        check("instr_pc", instr_pc, e[31:0]);
        check("opcode", 32'(opcode), 32'(ew[6:0]));
        check("funct3", 32'(funct3), 32'(ew[14:12]));
        check("funct7", 32'(funct7), 32'(ew[31:25]));
        for (int i = 0; i < hold; i++) begin
            instr_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, ew);
            check("stall_pc", instr_pc, e[31:0]);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end
        instr_ready = 1'b1;
        redirect    = redir;
        redirect_pc = tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        exp_pc = redir ? (tgt & ~32'h3) : exp_pc + 32'd4;
        check("hs_valid_drop", 32'(instr_valid), 32'd0);
        check("hs_req", 32'(imem_req), 32'd1);
        check("hs_next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        exp_pc      = 32'h0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h13);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_to_req", 32'(imem_req), 32'd1);

        // Back-to-back fetches at 0,4,8
        fetch(0, 1'b0, 32'h0);
        fetch(0, 1'b0, 32'h0);
        fetch(0, 1'b0, 32'h0);

        // Grant stall for 4 cycles; stray rvalid in REQ ignored
        wait_req();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, exp_pc);
            check("stall_no_valid", 32'(instr_valid), 32'd0);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        fetch(0, 1'b0, 32'h0);

        // Decode back-pressure for 5 cycles
        fetch(5, 1'b0, 32'h0);

        // Redirect in WAIT before rvalid; late response (k=2) discarded
        wait_req();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect = 1'b0;
        check("flush_no_req", 32'(imem_req), 32'd0);
        check("flush_no_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("flush_wait_no_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("flush_drop_valid", 32'(instr_valid), 32'd0);
        check("flush_req", 32'(imem_req), 32'd1);
        check("flush_addr", imem_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        fetch(0, 1'b0, 32'h0);

        // Redirect in REQ without grant: new address next cycle
        wait_req();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect = 1'b0;
        check("req_redir_req", 32'(imem_req), 32'd1);
        check("req_redir_addr", imem_addr, 32'h0000_0040);
        exp_pc = 32'h0000_0040;

        // Redirect coincident with rvalid in WAIT: data dropped, straight to REQ
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        check("wait_redir_valid", 32'(instr_valid), 32'd0);
        check("wait_redir_req", 32'(imem_req), 32'd1);
        check("wait_redir_addr", imem_addr, 32'h0000_0080);
        check("wait_redir_keep_instr_pc", instr_pc, 32'h0000_0100);
        exp_pc = 32'h0000_0080;

        // Redirect with handshake in HOLD; low bits of target masked; then PC wrap
        fetch(0, 1'b1, 32'hFFFF_FFFF);
        fetch(0, 1'b0, 32'h0);
        fetch(0, 1'b0, 32'h0);

        // Reset asserted while in WAIT; late rvalid after release ignored
        wait_req();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0000_0013);
        check("midrst_instr_pc", instr_pc, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("postrst_req", 32'(imem_req), 32'd1);
        check("postrst_valid", 32'(instr_valid), 32'd0);
        check("postrst_instr", instr, 32'h0000_0013);
        exp_pc = 32'h0;
        fetch(0, 1'b0, 32'h0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
